pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Parametrised program-counter generator for the fetch stage. Replaces the fixed 64-bit,
//   +4-only counter. Adds: configurable XLEN and reset vector; RVC (+2) stepping;
//   N prioritised redirect channels; redirect-target alignment checking; halt/resume FSM.
//   Drives the fetch address and a valid qualifier to the instruction memory/fetch buffer.
// PARAMETERS
//   XLEN         64   PC width in bits
//   RESET_VECTOR 0    PC value loaded on reset (XLEN bits, must be 2/4-aligned per C_EXT)
//   C_EXT        1    1: 16-bit instructions legal, step 2 allowed, 2-byte alignment; 0: 4-byte only
//   N_REDIR      3    redirect channels; index 0 = highest priority (trap), N_REDIR>=1
// PORTS
//   i_clk          in   1             clock, all state updates on rising edge
//   i_rst          in   1             synchronous, active-high reset
//   i_stall        in   1             hold PC (no increment); redirects still apply
//   i_compressed   in   1             current o_pc instruction is 16-bit; ignored if C_EXT=0
//   i_redir_valid  in   N_REDIR       per-channel redirect request
//   i_redir_pc     in   N_REDIR*XLEN  channel k target at [k*XLEN +: XLEN]
//   i_halt         in   1             request halt (debug/WFI)
//   i_resume       in   1             leave HALTED
//   o_pc           out  XLEN          current fetch address
//   o_pc_valid     out  1             o_pc is a fetch request (1 only in RUN)
//   o_misaligned   out  1             1-cycle pulse: rejected misaligned redirect
//   o_bad_pc       out  XLEN          target of last rejected redirect (held until next reject)
// BEHAVIOUR
//   Reset (i_rst=1 at edge): state=BOOT, o_pc=RESET_VECTOR, o_pc_valid=0, o_misaligned=0,
//     o_bad_pc=0. Reset overrides every other input, in any state.
//   States: BOOT, RUN, HALTED, FAULT. o_pc_valid = (state==RUN), registered, no comb paths.
//   BOOT: one cycle, PC held, -> RUN (or HALTED if i_halt=1). Redirects in BOOT are applied.
//   Redirect select: lowest index k with i_redir_valid[k]=1; others ignored that cycle.
//   Alignment: target[0]!=0 misaligned; if C_EXT=0 also target[1]!=0 misaligned.
//   Aligned redirect: o_pc <= target next edge (1-cycle latency), regardless of i_stall.
//   Misaligned redirect: o_pc unchanged, o_misaligned=1 next cycle, o_bad_pc<=target, state->FAULT.
//   RUN, no redirect: if !i_stall, o_pc <= o_pc + step; step=2 if (C_EXT && i_compressed) else 4.
//     Sum is modulo 2^XLEN (all-ones-minus-3 + 4 wraps to 0, no flag).
//   RUN + i_halt: -> HALTED; same-cycle increment suppressed; a same-cycle redirect is applied.
//   HALTED: PC held; aligned redirects load PC, stay HALTED; misaligned -> FAULT.
//     i_resume -> RUN next edge; i_halt and i_resume together: stay HALTED.
//   FAULT: PC held, o_pc_valid=0; only an aligned channel-0 redirect exits: load PC, -> RUN.
//     Other channels ignored in FAULT; misaligned channel-0 re-pulses o_misaligned, stays FAULT.
//   i_resume ignored outside HALTED; i_halt ignored in FAULT.
// TESTING
//   Reset, RESET_VECTOR=0x8000_0000: BOOT 1 cycle valid=0, then 0x8000_0000,+4,+4 valid=1.
//   C_EXT=1, i_compressed=1,0,1 from 0x100 -> o_pc 0x102,0x106,0x108; stall holds value.
//   Ch2=0x200 and ch0=0x400 same cycle while stalled -> o_pc=0x400 next cycle.
//   C_EXT=0, ch1 target 0x202 -> o_pc unchanged, o_misaligned pulse, o_bad_pc=0x202, valid=0;
//     ch1 0x300 ignored; ch0 0x500 -> o_pc=0x500, RUN.
//   o_pc=0xFFFF_FFFF_FFFF_FFFC, no stall -> 0x0; i_halt -> held, valid=0; i_resume -> +4.
//   i_rst asserted mid-RUN with redirect pending -> RESET_VECTOR, BOOT, redirect dropped.

Source files
------------

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program-counter generator for the fetch stage.
//
// Produces the fetch address (o_pc) and its qualifier (o_pc_valid). The PC
// advances by 4 or, with the compressed extension enabled, by 2 when the
// instruction at the current PC is 16 bits wide. Any number of prioritised
// redirect channels can load a new PC; channel 0 has the highest priority and
// is the only channel that can recover from a fault. A redirect target that
// is not aligned to the legal instruction size is rejected and moves the
// generator into FAULT.
//
// Parameters
//   XLEN          PC width in bits
//   RESET_VECTOR  PC loaded on reset
//   C_EXT         1: 16-bit instructions legal (2-byte alignment), 0: 4-byte only
//   N_REDIR       number of redirect channels (index 0 = highest priority)
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous active-high reset, overrides everything
//   i_stall        hold the PC; redirects still apply
//   i_compressed   instruction at o_pc is 16-bit (ignored when C_EXT=0)
//   i_redir_valid  per-channel redirect request
//   i_redir_pc     channel k target at [k*XLEN +: XLEN]
//   i_halt         request halt (debug / WFI)
//   i_resume       leave HALTED
//   o_pc           current fetch address
//   o_pc_valid     o_pc is a fetch request (high only in RUN)
//   o_misaligned   one-cycle pulse after a rejected misaligned redirect
//   o_bad_pc       target of the most recent rejected redirect
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter bit              C_EXT        = 1'b1,
  parameter int              N_REDIR      = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_stall,
  input  logic                    i_compressed,
  input  logic [N_REDIR-1:0]      i_redir_valid,
  input  logic [N_REDIR*XLEN-1:0] i_redir_pc,
  input  logic                    i_halt,
  input  logic                    i_resume,
  output logic [XLEN-1:0]         o_pc,
  output logic                    o_pc_valid,
  output logic                    o_misaligned,
  output logic [XLEN-1:0]         o_bad_pc
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            valid_reg;
  logic            misaligned_reg, misaligned_next;
  logic [XLEN-1:0] bad_pc_reg, bad_pc_next;

  // ---------------------------------------------------------------------------
  // Per-channel target extraction and alignment check
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]    redir_tgt [N_REDIR];
  logic [N_REDIR-1:0] redir_bad;

  for (genvar gi = 0; gi < N_REDIR; gi++) begin : g_chan
    assign redir_tgt[gi] = i_redir_pc[gi*XLEN +: XLEN];
    // Bit 0 is always illegal; bit 1 only matters without 16-bit instructions.
    if (C_EXT) begin : g_align2
      assign redir_bad[gi] = redir_tgt[gi][0];
    end else begin : g_align4
      assign redir_bad[gi] = |redir_tgt[gi][1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Priority select: isolate the lowest set request bit, then OR-reduce the
  // masked targets. Only one mask bit can be set, so the OR is a clean mux.
  // ---------------------------------------------------------------------------
  logic [N_REDIR-1:0] sel_onehot;
  logic [XLEN-1:0]    tgt_chain [N_REDIR+1];
  logic               sel_valid;
  logic [XLEN-1:0]    sel_tgt;
  logic               sel_bad;

  assign sel_onehot   = i_redir_valid & (~i_redir_valid + N_REDIR'(1));
  assign tgt_chain[0] = '0;

  for (genvar gi = 0; gi < N_REDIR; gi++) begin : g_sel
    assign tgt_chain[gi+1] = tgt_chain[gi] | (redir_tgt[gi] & {XLEN{sel_onehot[gi]}});
  end

  assign sel_valid = |i_redir_valid;
  assign sel_tgt   = tgt_chain[N_REDIR];
  assign sel_bad   = |(sel_onehot & redir_bad);

  // ---------------------------------------------------------------------------
  // Sequential increment step
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] step;
  assign step = (C_EXT && i_compressed) ? XLEN'(2) : XLEN'(4);

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic
  // ---------------------------------------------------------------------------
  logic            take_redir;
  logic [XLEN-1:0] take_tgt;
  logic            take_bad;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    misaligned_next = 1'b0;
    bad_pc_next     = bad_pc_reg;

    // In FAULT only channel 0 is listened to; elsewhere the priority winner.
    take_redir = sel_valid;
    take_tgt   = sel_tgt;
    take_bad   = sel_bad;
    if (state_reg == ST_FAULT) begin
      take_redir = i_redir_valid[0];
      take_tgt   = redir_tgt[0];
      take_bad   = redir_bad[0];
    end

    // Baseline behaviour with no redirect.
    case (state_reg)
      ST_BOOT: begin
        state_next = i_halt ? ST_HALTED : ST_RUN;
      end
      ST_RUN: begin
        // A halt request also suppresses the increment of this cycle.
        if (i_halt) begin
          state_next = ST_HALTED;
        end else if (!i_stall) begin
          pc_next = pc_reg + step;
        end
      end
      ST_HALTED: begin
        // Halt wins when both halt and resume are raised together.
        if (i_resume && !i_halt) begin
          state_next = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (take_redir && !take_bad) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase

    // A redirect overrides the sequential PC; a misaligned one freezes the PC
    // and forces FAULT regardless of the baseline transition above.
    if (take_redir) begin
      if (take_bad) begin
        pc_next         = pc_reg;
        state_next      = ST_FAULT;
        misaligned_next = 1'b1;
        bad_pc_next     = take_tgt;
      end else begin
        pc_next = take_tgt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_BOOT;
      pc_reg         <= RESET_VECTOR;
      valid_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      bad_pc_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      // Registered from the next state so the qualifier carries no comb path.
      valid_reg      <= (state_next == ST_RUN);
      misaligned_reg <= misaligned_next;
      bad_pc_reg     <= bad_pc_next;
    end
  end

  assign o_pc         = pc_reg;
  assign o_pc_valid   = valid_reg;
  assign o_misaligned = misaligned_reg;
  assign o_bad_pc     = bad_pc_reg;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen.
//
// Two instances share all inputs:
//   dut 0: C_EXT=1, RESET_VECTOR=0x8000_0000
//   dut 1: C_EXT=0, RESET_VECTOR=0
// A behavioural model tracks each instance from the documented rules; every
// scenario task compares both instances against it after each clock, and
// adds fixed expected values where the scenario pins them down.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  localparam int XLEN = 64;
  localparam int NR   = 3;
  localparam logic [63:0] RV0 = 64'h0000_0000_8000_0000;

  localparam int S_BOOT   = 0;
  localparam int S_RUN    = 1;
  localparam int S_HALTED = 2;
  localparam int S_FAULT  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              comp;
  logic [NR-1:0]     rv;
  logic [NR*XLEN-1:0] rpc;
  logic              halt;
  logic              resume;

  logic [63:0] pc0, pc1, bad0, bad1;
  logic        v0, v1, m0, m1;

  int checks = 0;
  int errors = 0;

  // Model state per instance
  int          m_st  [2];
  logic [63:0] m_pc  [2];
  logic        m_mis [2];
  logic [63:0] m_bad [2];

  logic [129:0] act [2];
  assign act[0] = {pc0, v0, m0, bad0};
  assign act[1] = {pc1, v1, m1, bad1};

  always #5 clk = ~clk;

  pc_gen #(.XLEN(64), .RESET_VECTOR(RV0), .C_EXT(1'b1), .N_REDIR(NR)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_compressed(comp),
    .i_redir_valid(rv), .i_redir_pc(rpc), .i_halt(halt), .i_resume(resume),
    .o_pc(pc0), .o_pc_valid(v0), .o_misaligned(m0), .o_bad_pc(bad0)
  );

  pc_gen #(.XLEN(64), .RESET_VECTOR(64'h0), .C_EXT(1'b0), .N_REDIR(NR)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_compressed(comp),
    .i_redir_valid(rv), .i_redir_pc(rpc), .i_halt(halt), .i_resume(resume),
    .o_pc(pc1), .o_pc_valid(v1), .o_misaligned(m1), .o_bad_pc(bad1)
  );

  function automatic logic [129:0] exp_vec(int d);
    return {m_pc[d], (m_st[d] == S_RUN), m_mis[d], m_bad[d]};
  endfunction

  // Apply one clock edge of the documented behaviour to the model.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int unsigned align;
      bit          found;
      logic [63:0] tgt;
      align = (d == 0) ? 2 : 4;
      if (rst) begin
        m_st[d]  = S_BOOT;
        m_pc[d]  = (d == 0) ? RV0 : 64'h0;
        m_mis[d] = 1'b0;
        m_bad[d] = 64'h0;
        continue;
      end
      found = 1'b0;
      tgt   = 64'h0;
      for (int k = 0; k < NR; k++) begin
        if (!found && rv[k] && (m_st[d] != S_FAULT || k == 0)) begin
          found = 1'b1;
          tgt   = rpc[k*XLEN +: XLEN];
        end
      end
      m_mis[d] = 1'b0;
      if (found && (tgt % align) != 0) begin
        m_mis[d] = 1'b1;
        m_bad[d] = tgt;
        m_st[d]  = S_FAULT;
      end else begin
        if (found) m_pc[d] = tgt;
        case (m_st[d])
          S_BOOT:   m_st[d] = halt ? S_HALTED : S_RUN;
          S_RUN: begin
            if (halt) m_st[d] = S_HALTED;
            else if (!found && !stall) m_pc[d] = m_pc[d] + ((d == 0 && comp) ? 2 : 4);
          end
          S_HALTED: if (resume && !halt) m_st[d] = S_RUN;
          default:  if (found) m_st[d] = S_RUN;
        endcase
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; comp = 0; rv = '0; rpc = '0; halt = 0; resume = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act[d] !== exp_vec(d)) begin
        errors++; $display("FAIL reset_state dut%0d got %h want %h", d, act[d], exp_vec(d));
      end
    end
    checks++;
    if (pc0 !== RV0 || v0 !== 1'b0 || m0 !== 1'b0 || bad0 !== 64'h0) begin
      errors++; $display("FAIL reset_vector got pc=%h v=%b m=%b bad=%h want pc=%h v=0 m=0 bad=0", pc0, v0, m0, bad0, RV0);
    end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++; $display("FAIL boot_seq dut%0d step%0d got %h want %h", d, i, act[d], exp_vec(d));
        end
      end
      checks++;
      if (pc0 !== RV0 + 64'(4*i) || v0 !== 1'b1) begin
        errors++; $display("FAIL boot_run step%0d got pc=%h v=%b want pc=%h v=1", i, pc0, v0, RV0 + 64'(4*i));
      end
    end
  endtask

  task automatic test_compressed();
    logic [63:0] want0 [5];
    want0[0] = 64'h100; want0[1] = 64'h102; want0[2] = 64'h106; want0[3] = 64'h108; want0[4] = 64'h108;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      case (i)
        0: begin rv = 3'b010; rpc[1*XLEN +: XLEN] = 64'h100; end
        1: comp = 1;
        2: comp = 0;
        3: comp = 1;
        default: begin stall = 1; comp = 1; end
      endcase
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++; $display("FAIL compressed dut%0d step%0d got %h want %h", d, i, act[d], exp_vec(d));
        end
      end
      checks++;
      if (pc0 !== want0[i]) begin
        errors++; $display("FAIL rvc_step step%0d got pc=%h want %h", i, pc0, want0[i]);
      end
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    stall = 1; rv = 3'b101;
    rpc[2*XLEN +: XLEN] = 64'h200;
    rpc[0 +: XLEN]      = 64'h400;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act[d] !== exp_vec(d)) begin
        errors++; $display("FAIL priority dut%0d got %h want %h", d, act[d], exp_vec(d));
      end
    end
    checks++;
    if (pc0 !== 64'h400 || pc1 !== 64'h400) begin
      errors++; $display("FAIL priority_pc got %h/%h want 400/400", pc0, pc1);
    end
  endtask

  task automatic test_misaligned();
    // step: 0 ch1 0x202, 1 idle, 2 ch1 0x300, 3 ch0 0x500, 4 ch0 0x501, 5 ch0 0x503, 6 ch0 0x600
    logic [63:0] tg [7];
    int          ch [7];
    tg[0] = 64'h202; ch[0] = 1;  tg[1] = 64'h0;   ch[1] = -1;
    tg[2] = 64'h300; ch[2] = 1;  tg[3] = 64'h500; ch[3] = 0;
    tg[4] = 64'h501; ch[4] = 0;  tg[5] = 64'h503; ch[5] = 0;
    tg[6] = 64'h600; ch[6] = 0;
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      if (ch[i] >= 0) begin
        rv[ch[i]] = 1'b1;
        rpc[ch[i]*XLEN +: XLEN] = tg[i];
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++; $display("FAIL misaligned dut%0d step%0d got %h want %h", d, i, act[d], exp_vec(d));
        end
      end
      if (i == 0) begin
        checks++;
        if (pc1 !== 64'h400 || m1 !== 1'b1 || bad1 !== 64'h202 || v1 !== 1'b0) begin
          errors++; $display("FAIL reject_202 got pc=%h m=%b bad=%h v=%b want pc=400 m=1 bad=202 v=0", pc1, m1, bad1, v1);
        end
      end
      if (i == 2) begin
        checks++;
        if (pc1 !== 64'h400 || v1 !== 1'b0 || m1 !== 1'b0) begin
          errors++; $display("FAIL fault_ignore_ch1 got pc=%h v=%b m=%b want pc=400 v=0 m=0", pc1, v1, m1);
        end
      end
      if (i == 3) begin
        checks++;
        if (pc1 !== 64'h500 || v1 !== 1'b1) begin
          errors++; $display("FAIL fault_exit got pc=%h v=%b want pc=500 v=1", pc1, v1);
        end
      end
      if (i == 5) begin
        checks++;
        if (m0 !== 1'b1 || bad0 !== 64'h503 || pc0 !== 64'h500) begin
          errors++; $display("FAIL refault_pulse got m=%b bad=%h pc=%h want m=1 bad=503 pc=500", m0, bad0, pc0);
        end
      end
    end
  endtask

  task automatic test_wrap_halt();
    // step: 0 ch0 ..FFFC, 1 run, 2 halt, 3 idle, 4 halt+resume, 5 resume, 6 run
    logic [63:0] want_pc [7];
    logic        want_v  [7];
    want_pc[0] = 64'hFFFF_FFFF_FFFF_FFFC; want_v[0] = 1;
    want_pc[1] = 64'h0; want_v[1] = 1;
    want_pc[2] = 64'h0; want_v[2] = 0;
    want_pc[3] = 64'h0; want_v[3] = 0;
    want_pc[4] = 64'h0; want_v[4] = 0;
    want_pc[5] = 64'h0; want_v[5] = 1;
    want_pc[6] = 64'h4; want_v[6] = 1;
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      case (i)
        0: begin rv = 3'b001; rpc[0 +: XLEN] = 64'hFFFF_FFFF_FFFF_FFFC; end
        2: halt = 1;
        4: begin halt = 1; resume = 1; end
        5: resume = 1;
        default: ;
      endcase
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++; $display("FAIL wrap_halt dut%0d step%0d got %h want %h", d, i, act[d], exp_vec(d));
        end
      end
      checks++;
      if (pc1 !== want_pc[i] || v1 !== want_v[i]) begin
        errors++; $display("FAIL wrap_halt_fixed step%0d got pc=%h v=%b want pc=%h v=%b", i, pc1, v1, want_pc[i], want_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    clear_inputs();
    rst = 1; rv = 3'b001; rpc[0 +: XLEN] = 64'h700;
    tick();
    rst = 0; clear_inputs();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act[d] !== exp_vec(d)) begin
        errors++; $display("FAIL reset_mid dut%0d got %h want %h", d, act[d], exp_vec(d));
      end
    end
    checks++;
    if (pc0 !== RV0 || v0 !== 1'b0 || pc1 !== 64'h0) begin
      errors++; $display("FAIL reset_mid_fixed got pc0=%h v0=%b pc1=%h want %h 0 0", pc0, v0, pc1, RV0);
    end
    tick();
    checks++;
    if (pc0 !== RV0 || v0 !== 1'b1) begin
      errors++; $display("FAIL reset_mid_boot got pc0=%h v0=%b want %h 1", pc0, v0, RV0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      stall  = ($urandom_range(0, 2) == 0);
      comp   = $urandom_range(0, 1);
      halt   = ($urandom_range(0, 11) == 0);
      resume = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < NR; k++) begin
        logic [63:0] t;
        rv[k] = ($urandom_range(0, 6) == 0);
        t = {$urandom, $urandom};
        // Mostly aligned targets, with a mix of 2-aligned and odd ones.
        case ($urandom_range(0, 5))
          0:       t[1:0] = 2'b10;
          1:       t[0]   = 1'b1;
          default: t[1:0] = 2'b00;
        endcase
        rpc[k*XLEN +: XLEN] = t;
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++; $display("FAIL random dut%0d cyc%0d got %h want %h", d, i, act[d], exp_vec(d));
        end
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_compressed();
    test_priority();
    test_misaligned();
    test_wrap_halt();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
